jpeg_rle_symbolizer: RTL

//  Run-length/category symbolizer for JPEG baseline entropy coding. Consumes 64 zig-zag-ordered

---
 rtl/jpeg_rle_pkg.sv | 31 +++
 rtl/jpeg_rle_category.sv | 44 ++++
 rtl/jpeg_rle_symbolizer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_rle_pkg.sv
// Purpose: shared types and widths for the JPEG run-length/category symbolizer.
//   state_e   : symbolizer FSM states
//   BLK_LAST  : zig-zag index of the final coefficient in an 8x8 block
//   ZRL_RUN   : run field carried by a ZRL (16 zeros) symbol
//   size_width: category field width needed for a given amplitude width
package jpeg_rle_pkg;

  localparam int unsigned COEF_W_DEF = 12;
  localparam int unsigned AMP_W_DEF  = COEF_W_DEF + 1;
  localparam int unsigned RUN_W      = 4;
  localparam int unsigned IDX_W      = 6;
  localparam int unsigned RUNCNT_W   = 6;

  localparam logic [IDX_W-1:0] BLK_LAST = 6'd63;
  localparam logic [RUN_W-1:0] ZRL_RUN  = 4'd15;

  typedef enum logic [1:0] {
    ST_DC,
    ST_AC,
    ST_ZRL
  } state_e;

  // Bits needed to encode categories 0..amp_w (the top value is reachable only by the
  // most negative AMP_W code, kept representable for safety).
  function automatic int unsigned size_width(input int unsigned amp_w);
    return $clog2(amp_w + 1);
  endfunction

  localparam int unsigned SIZE_W_DEF = size_width(AMP_W_DEF);

endpackage

// File: rtl/jpeg_rle_category.sv
// Purpose: combinational JPEG magnitude category and amplitude bits for a signed value.
// Ports:
//   i_val      in  AMP_W   two's-complement value
//   o_size_c   out SIZE_W  bit length of |i_val| (0 for 0)
//   o_amp_c    out AMP_W   i_val if >=0, else (i_val-1) masked to the low o_size_c bits
module jpeg_rle_category
  import jpeg_rle_pkg::*;
#(
  parameter int unsigned AMP_W  = AMP_W_DEF,
  parameter int unsigned SIZE_W = SIZE_W_DEF
) (
  input  logic [AMP_W-1:0]  i_val,
  output logic [SIZE_W-1:0] o_size_c,
  output logic [AMP_W-1:0]  o_amp_c
);

  logic              w_neg;
  logic [AMP_W-1:0]  w_mag;
  logic [AMP_W-1:0]  w_vm1;
  logic [AMP_W-1:0]  w_mask;

  assign w_neg = i_val[AMP_W-1];
  assign w_mag = w_neg ? (~i_val + AMP_W'(1)) : i_val;
  assign w_vm1 = i_val - AMP_W'(1);

  // Category: position of the highest set magnitude bit, plus one.
  always_comb begin
    o_size_c = '0;
    for (int i = 0; i < int'(AMP_W); i++) begin
      if (w_mag[i]) o_size_c = SIZE_W'(i + 1);
    end
  end

  // Keep only the low o_size_c bits of a negative value's (v-1) form.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(AMP_W); i++) begin
      if (i < int'(o_size_c)) w_mask[i] = 1'b1;
    end
  end

  assign o_amp_c = w_neg ? (w_vm1 & w_mask) : i_val;

endmodule

// File: rtl/jpeg_rle_symbolizer.sv
// Purpose: JPEG baseline run-length/category symbolizer. Takes 64 zig-zag quantized
//   coefficients per block (index 0 = DC) and emits (run,size,amp) symbols with ZRL/EOB.
//   Optional feature macro: JPEG_RLE_DC_DIFF_EN -- when defined, DC is emitted as the
//   difference from the previous block's DC and dc_clr resets the predictor; otherwise
//   DC is emitted raw and dc_clr is ignored.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     coefficient handshake, in_coef signed COEF_W
//   dc_clr                restart marker, next DC predicts from 0 (sticky)
//   out_valid/out_ready   symbol handshake, one-entry registered output
//   out_run/size/amp      symbol fields; out_dc/out_eob/out_last symbol flags
module jpeg_rle_symbolizer
  import jpeg_rle_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned AMP_W  = COEF_W + 1,
  parameter int unsigned SIZE_W = SIZE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  input  logic              dc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RUN_W-1:0]  out_run,
  output logic [SIZE_W-1:0] out_size,
  output logic [AMP_W-1:0]  out_amp,
  output logic              out_dc,
  output logic              out_eob,
  output logic              out_last
);

  localparam int unsigned EXT_W = AMP_W - COEF_W;

  state_e              r_state, w_state_nx;
  logic [IDX_W-1:0]    r_idx, w_idx_nx;
  logic [RUNCNT_W-1:0] r_run, w_run_nx;
  logic [COEF_W-1:0]   r_lat_coef, w_lat_coef_nx;
  logic                r_lat_last, w_lat_last_nx;

  logic                r_out_valid, w_ov_nx;
  logic [RUN_W-1:0]    r_out_run, w_orun_nx;
  logic [SIZE_W-1:0]   r_out_size, w_osize_nx;
  logic [AMP_W-1:0]    r_out_amp, w_oamp_nx;
  logic                r_out_dc, w_odc_nx;
  logic                r_out_eob, w_oeob_nx;
  logic                r_out_last, w_olast_nx;

  logic                w_slot;
  logic                w_in_ready;
  logic                w_acc;
  logic                w_coef_nz;
  logic                w_last_idx;
  logic                w_run_ge16;
  logic [AMP_W-1:0]    w_coef_ext;
  logic [AMP_W-1:0]    w_lat_ext;
  logic [AMP_W-1:0]    w_dc_val;
  logic [AMP_W-1:0]    w_cat_in;
  logic [SIZE_W-1:0]   w_size;
  logic [AMP_W-1:0]    w_amp;

`ifdef JPEG_RLE_DC_DIFF_EN
  logic [COEF_W-1:0]   r_pred, w_pred_nx;
  logic                r_clr_pend, w_clr_pend_nx;
  logic [COEF_W-1:0]   w_pred_eff;
`else
  logic                w_unused_dc_clr;
  assign w_unused_dc_clr = dc_clr;
`endif

  // Handshake: input only moves while the output slot is free or draining this cycle.
  assign w_slot     = !r_out_valid || out_ready;
  assign w_in_ready = ((r_state == ST_DC) || (r_state == ST_AC)) && w_slot;
  assign w_acc      = in_valid && w_in_ready;
  assign w_coef_nz  = |in_coef;
  assign w_last_idx = (r_idx == BLK_LAST);
  assign w_run_ge16 = (r_run >= RUNCNT_W'(16));

  assign w_coef_ext = {{EXT_W{in_coef[COEF_W-1]}}, in_coef};
  assign w_lat_ext  = {{EXT_W{r_lat_coef[COEF_W-1]}}, r_lat_coef};

`ifdef JPEG_RLE_DC_DIFF_EN
  // A restart marker this cycle or earlier forces a zero prediction.
  assign w_pred_eff = (dc_clr || r_clr_pend) ? '0 : r_pred;
  assign w_dc_val   = w_coef_ext - {{EXT_W{w_pred_eff[COEF_W-1]}}, w_pred_eff};
`else
  assign w_dc_val   = w_coef_ext;
`endif

  // One category unit shared by DC, AC and the deferred (post-ZRL) coefficient.
  always_comb begin
    w_cat_in = w_coef_ext;
    if (r_state == ST_DC)  w_cat_in = w_dc_val;
    if (r_state == ST_ZRL) w_cat_in = w_lat_ext;
  end

  jpeg_rle_category #(
    .AMP_W  (AMP_W),
    .SIZE_W (SIZE_W)
  ) u_category (
    .i_val    (w_cat_in),
    .o_size_c (w_size),
    .o_amp_c  (w_amp)
  );

  // Next-state and output-register load.
  always_comb begin
    w_state_nx    = r_state;
    w_idx_nx      = r_idx;
    w_run_nx      = r_run;
    w_lat_coef_nx = r_lat_coef;
    w_lat_last_nx = r_lat_last;
    w_ov_nx       = r_out_valid && !out_ready;
    w_orun_nx     = r_out_run;
    w_osize_nx    = r_out_size;
    w_oamp_nx     = r_out_amp;
    w_odc_nx      = r_out_dc;
    w_oeob_nx     = r_out_eob;
    w_olast_nx    = r_out_last;
`ifdef JPEG_RLE_DC_DIFF_EN
    w_pred_nx     = r_pred;
    w_clr_pend_nx = r_clr_pend | dc_clr;
`endif

    case (r_state)
      ST_DC: begin
        if (w_acc) begin
          w_ov_nx    = 1'b1;
          w_orun_nx  = '0;
          w_osize_nx = w_size;
          w_oamp_nx  = w_amp;
          w_odc_nx   = 1'b1;
          w_oeob_nx  = 1'b0;
          w_olast_nx = 1'b0;
          w_state_nx = ST_AC;
          w_idx_nx   = IDX_W'(1);
          w_run_nx   = '0;
`ifdef JPEG_RLE_DC_DIFF_EN
          w_pred_nx     = in_coef;
          w_clr_pend_nx = 1'b0;
`endif
        end
      end

      ST_AC: begin
        if (w_acc) begin
          if (!w_coef_nz) begin
            if (w_last_idx) begin
              // Trailing zeros of any length collapse into a single EOB.
              w_ov_nx    = 1'b1;
              w_orun_nx  = '0;
              w_osize_nx = '0;
              w_oamp_nx  = '0;
              w_odc_nx   = 1'b0;
              w_oeob_nx  = 1'b1;
              w_olast_nx = 1'b1;
              w_state_nx = ST_DC;
              w_idx_nx   = '0;
              w_run_nx   = '0;
            end else begin
              w_run_nx = r_run + RUNCNT_W'(1);
              w_idx_nx = r_idx + IDX_W'(1);
            end
          end else if (!w_run_ge16) begin
            w_ov_nx    = 1'b1;
            w_orun_nx  = r_run[RUN_W-1:0];
            w_osize_nx = w_size;
            w_oamp_nx  = w_amp;
            w_odc_nx   = 1'b0;
            w_oeob_nx  = 1'b0;
            w_olast_nx = w_last_idx;
            w_run_nx   = '0;
            w_idx_nx   = w_last_idx ? '0 : (r_idx + IDX_W'(1));
            if (w_last_idx) w_state_nx = ST_DC;
          end else begin
            // Long run: park the coefficient and drain ZRLs first.
            w_lat_coef_nx = in_coef;
            w_lat_last_nx = w_last_idx;
            w_idx_nx      = w_last_idx ? '0 : (r_idx + IDX_W'(1));
            w_state_nx    = ST_ZRL;
          end
        end
      end

      ST_ZRL: begin
        if (w_slot) begin
          w_ov_nx   = 1'b1;
          w_odc_nx  = 1'b0;
          w_oeob_nx = 1'b0;
          if (w_run_ge16) begin
            w_orun_nx  = ZRL_RUN;
            w_osize_nx = '0;
            w_oamp_nx  = '0;
            w_olast_nx = 1'b0;
            w_run_nx   = r_run - RUNCNT_W'(16);
          end else begin
            w_orun_nx  = r_run[RUN_W-1:0];
            w_osize_nx = w_size;
            w_oamp_nx  = w_amp;
            w_olast_nx = r_lat_last;
            w_run_nx   = '0;
            w_state_nx = r_lat_last ? ST_DC : ST_AC;
          end
        end
      end

      default: begin
        w_state_nx = ST_DC;
        w_idx_nx   = '0;
        w_run_nx   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_DC;
      r_idx       <= '0;
      r_run       <= '0;
      r_lat_coef  <= '0;
      r_lat_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_run   <= '0;
      r_out_size  <= '0;
      r_out_amp   <= '0;
      r_out_dc    <= 1'b0;
      r_out_eob   <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_idx       <= w_idx_nx;
      r_run       <= w_run_nx;
      r_lat_coef  <= w_lat_coef_nx;
      r_lat_last  <= w_lat_last_nx;
      r_out_valid <= w_ov_nx;
      r_out_run   <= w_orun_nx;
      r_out_size  <= w_osize_nx;
      r_out_amp   <= w_oamp_nx;
      r_out_dc    <= w_odc_nx;
      r_out_eob   <= w_oeob_nx;
      r_out_last  <= w_olast_nx;
    end
  end

`ifdef JPEG_RLE_DC_DIFF_EN
  // DC predictor and sticky restart flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred     <= '0;
      r_clr_pend <= 1'b0;
    end else begin
      r_pred     <= w_pred_nx;
      r_clr_pend <= w_clr_pend_nx;
    end
  end
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_run   = r_out_run;
  assign out_size  = r_out_size;
  assign out_amp   = r_out_amp;
  assign out_dc    = r_out_dc;
  assign out_eob   = r_out_eob;
  assign out_last  = r_out_last;

endmodule
